ucounter_n: RTL and testbench
=============================

Name: ucounter_n

Overview:
- Parametrised universal up/down counter/timer; next generation of the team's 8-bit universal counter.
- Adds generic width, a clock-enable prescaler, four terminal-count modes (wrap, stop, auto-reload, one-shot), a sticky overflow flag, compare-match and a cascadable carry_out.
- Used standalone as a timer or chained (carry_out -> carry_in) into wider counters.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- PRESCALE_W, 4, prescaler divisor width.
- RESET_VAL, 0, value of dcount after reset (WIDTH bits).

Ports:
- clk  in  1  clock; all state updates on posedge.
- _areset  in  1  synchronous, active-high reset. Single clock; reset is sampled only on the clk rising edge.
- _aset  in  1  sync set: dcount <= all ones.
- _load  in  1  sync load: dcount <= preld_val and reload_reg <= preld_val.
- preld_val  in  WIDTH  preload/reload value.
- _updown  in  1  1 = count up, 0 = count down.
- mode  in  2  terminal-count mode: 0 WRAP, 1 STOP, 2 RELOAD, 3 ONESHOT.
- carry_in  in  1  count enable (cascade input).
- start  in  1  sets running.
- prescale  in  PRESCALE_W  divisor minus 1; 0 = step on every enabled cycle.
- compare_val  in  WIDTH  match value.
- clr_ovf  in  1  clears ovf_sticky.
- dcount  out  WIDTH  counter value.
- carry_out  out  1  combinational: tick && terminal.
- overflow  out  1  registered 1-cycle pulse on a terminal event.
- ovf_sticky  out  1  sticky overflow flag.
- match  out  1  registered 1-cycle pulse.
- running  out  1  counting enabled.

Behaviour:
- Reset values:
  - dcount=RESET_VAL, reload_reg=RESET_VAL, prescaler count=0.
  - overflow=0, ovf_sticky=0, match=0, running=1.
- Priority, highest first: _areset > _aset > _load > start > count step.
  - _aset and _load clear the prescaler and produce no overflow or match.
  - _aset and _load do not change running.
  - _aset does not change reload_reg.
- Prescaler:
  - pcnt advances only when carry_in && running.
  - tick = carry_in && running && (pcnt >= prescale). On tick, pcnt <= 0.
  - The ">=" compare makes a mid-count decrease of prescale take effect on the next enabled cycle.
- terminal = (_updown && dcount==all ones) || (!_updown && dcount==0).
- carry_out = tick && terminal, combinational, same cycle as the step.
- Normal step (tick, not terminal): dcount +/- 1, modulo 2^WIDTH.
- Terminal event (tick && terminal):
  - overflow <= 1 for one cycle.
  - ovf_sticky <= 1; set wins over a simultaneous clr_ovf.
  - WRAP: dcount wraps (all ones -> 0 up, 0 -> all ones down). running stays 1.
  - STOP: dcount holds at the terminal value; running <= 0.
  - RELOAD: dcount <= reload_reg; running stays 1.
  - ONESHOT: dcount <= reload_reg; running <= 0.
- start sets running <= 1; it has no effect while already running. Step counting resumes on the next tick.
- match <= 1 for one cycle when a step (terminal or not) leaves the new dcount == compare_val. Loads, sets and resets never assert match.
- Changing mode or _updown mid-count takes effect on the next tick. dcount is not altered by the change.
- _areset mid-count restores all reset values in the same edge, including running=1.

Decomposition:
- Shared package ucounter_pkg:
  - mode encoding constants MODE_WRAP=2'd0, MODE_STOP=2'd1, MODE_RELOAD=2'd2, MODE_ONESHOT=2'd3.
  - mode typedef (2 bits).
- Sub-module ucounter_prescaler, parameter PRESCALE_W:
  - inputs: clk, _areset, clear, enable, prescale.
  - output: tick.

Test Plan:
- WIDTH=8, mode=WRAP, _updown=1, prescale=0, carry_in=1, load 8'hFD -> dcount FE, FF, 00. overflow pulses in the cycle after FF->00; carry_out high while dcount=FF; ovf_sticky=1 until clr_ovf.
- mode=STOP, _updown=0, load 8'h02 -> dcount 01, 00, then holds 00 with running=0. start -> wraps 00->FF? No: STOP re-triggers, dcount stays 00, second overflow pulse, running=0 again.
- mode=RELOAD, load 8'h05, _updown=1, _aset -> FF, next tick dcount=05. ONESHOT from 8'hFE with reload 05 -> FF, 05, then frozen at 05 until start.
- prescale=3, carry_in=1 -> dcount steps once every 4 cycles. Dropping carry_in for 2 cycles stretches that interval to 6. Changing prescale 3->1 while pcnt=2 -> tick next cycle.
- compare_val=8'h10, count up from 0E -> match single pulse after 0F->10. Loading 10 directly -> no match.
- Simultaneous _areset, _aset, _load and tick -> dcount=RESET_VAL, overflow=0, running=1. Simultaneous _aset and _load -> dcount=FF, reload_reg unchanged.

Source files
------------

// File: rtl/ucounter_pkg.sv
// Shared definitions for the universal up/down counter family.
// Mode encoding plus small helpers that classify terminal-count behaviour.
package ucounter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_STOP    = 2'd1,
    MODE_RELOAD  = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_t;

  // Modes that stop the counter after a terminal event.
  function automatic logic mode_halts(input mode_t m);
    return (m == MODE_STOP) || (m == MODE_ONESHOT);
  endfunction

  // Modes that restore reload_reg on a terminal event.
  function automatic logic mode_reloads(input mode_t m);
    return (m == MODE_RELOAD) || (m == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/ucounter_prescaler.sv
// Clock-enable divider: tick once every (prescale+1) enabled cycles.
// The >= compare lets a shrinking divisor take effect on the next enabled cycle.
module ucounter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  _areset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;

  assign tick = enable && (pcnt >= prescale);

  always_ff @(posedge clk) begin
    if (_areset)     pcnt <= '0;
    else if (clear)  pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else if (enable) pcnt <= pcnt + PRESCALE_W'(1);
  end

endmodule

// File: rtl/ucounter_n.sv
// Parametrised universal up/down counter/timer with prescaler, four
// terminal-count modes, sticky overflow, compare-match and cascade carry.
module ucounter_n
  import ucounter_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               PRESCALE_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  _areset,
  input  logic                  _aset,
  input  logic                  _load,
  input  logic [WIDTH-1:0]      preld_val,
  input  logic                  _updown,
  input  logic [1:0]            mode,
  input  logic                  carry_in,
  input  logic                  start,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      compare_val,
  input  logic                  clr_ovf,
  output logic [WIDTH-1:0]      dcount,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  ovf_sticky,
  output logic                  match,
  output logic                  running
);

  logic             tick;
  logic             terminal;
  logic             sync_wr;
  logic             term_evt;
  logic             halt;
  mode_t            mode_q;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] next_val;

  assign mode_q   = mode_t'(mode);
  assign sync_wr  = _aset | _load;
  assign terminal = _updown ? (dcount == '1) : (dcount == '0);
  assign carry_out = tick && terminal;
  // Set/load override the step, so they also suppress the terminal event.
  assign term_evt = tick && terminal && !sync_wr;

  ucounter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_presc (
    .clk      (clk),
    ._areset  (_areset),
    .clear    (sync_wr),
    .enable   (carry_in && running),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    step_val = _updown ? dcount + WIDTH'(1) : dcount - WIDTH'(1);
    next_val = step_val;
    halt     = 1'b0;
    if (terminal) begin
      // WRAP falls out of modulo arithmetic; STOP holds the terminal value.
      if (mode_reloads(mode_q))      next_val = reload_reg;
      else if (mode_q == MODE_STOP)  next_val = dcount;
      halt = mode_halts(mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (_areset) begin
      dcount     <= RESET_VAL;
      reload_reg <= RESET_VAL;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
      match      <= 1'b0;
      running    <= 1'b1;
    end else begin
      overflow <= 1'b0;
      match    <= 1'b0;
      if (_aset) begin
        dcount <= '1;
      end else if (_load) begin
        dcount     <= preld_val;
        reload_reg <= preld_val;
      end else begin
        if (start) running <= 1'b1;
        if (tick) begin
          dcount   <= next_val;
          overflow <= terminal;
          match    <= (next_val == compare_val);
          if (halt) running <= 1'b0;
        end
      end
      if (term_evt)     ovf_sticky <= 1'b1;
      else if (clr_ovf) ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ucounter_n.sv
// Directed bench for ucounter_n: integer-level reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_ucounter_n;

  localparam int W   = 8;
  localparam int PW  = 4;
  localparam int MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          ar = 1'b0, as = 1'b0, ld = 1'b0, ud = 1'b1;
  logic          ci = 1'b0, st = 1'b0, clr = 1'b0;
  logic [W-1:0]  pv = '0, cmp = 8'hAA;
  logic [1:0]    md = 2'd0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  dcount;
  logic          carry_out, overflow, ovf_sticky, match, running;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // reference model state
  int m_cnt = 0, m_reload = 0, m_pcnt = 0;
  bit m_run = 1, m_ovf = 0, m_sticky = 0, m_match = 0;

  always #5 clk = ~clk;

  ucounter_n #(.WIDTH(W), .PRESCALE_W(PW), .RESET_VAL(8'h00)) dut (
    .clk(clk), ._areset(ar), ._aset(as), ._load(ld), .preld_val(pv),
    ._updown(ud), .mode(md), .carry_in(ci), .start(st), .prescale(presc),
    .compare_val(cmp), .clr_ovf(clr), .dcount(dcount), .carry_out(carry_out),
    .overflow(overflow), .ovf_sticky(ovf_sticky), .match(match), .running(running)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_tick();
    return ci && m_run && (m_pcnt >= int'(presc));
  endfunction

  function automatic bit m_term();
    return ud ? (m_cnt == MAX) : (m_cnt == 0);
  endfunction

  // Model: applies the counter rules to plain integers on each rising edge.
  always @(posedge clk) begin
    bit tk, tm, old_run, ev;
    tk = m_tick(); tm = m_term(); old_run = m_run; ev = 0;
    if (ar) begin
      m_cnt = 0; m_reload = 0; m_pcnt = 0;
      m_run = 1; m_ovf = 0; m_sticky = 0; m_match = 0;
    end else begin
      m_ovf = 0; m_match = 0;
      if (as) begin
        m_cnt = MAX; m_pcnt = 0;
      end else if (ld) begin
        m_cnt = int'(pv); m_reload = int'(pv); m_pcnt = 0;
      end else begin
        if (st) m_run = 1;
        if (ci && old_run) m_pcnt = tk ? 0 : m_pcnt + 1;
        if (tk) begin
          if (tm) begin
            ev = 1;
            case (md)
              2'd0: m_cnt = ud ? 0 : MAX;
              2'd1: m_run = 0;
              2'd2: m_cnt = m_reload;
              default: begin m_cnt = m_reload; m_run = 0; end
            endcase
          end else begin
            m_cnt = ud ? (m_cnt + 1) % (MAX + 1) : (m_cnt + MAX) % (MAX + 1);
          end
          m_ovf = tm;
          m_match = (m_cnt == int'(cmp));
        end
      end
      if (ev) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
  end

  // Compare process: outputs are stable mid-cycle, inputs changed just after posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dcount",     int'(dcount),     m_cnt);
      check("running",    int'(running),    int'(m_run));
      check("overflow",   int'(overflow),   int'(m_ovf));
      check("ovf_sticky", int'(ovf_sticky), int'(m_sticky));
      check("match",      int'(match),      int'(m_match));
      check("carry_out",  int'(carry_out),  int'(m_tick() && m_term()));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    ld = 1'b1; pv = v; cycles(1); ld = 1'b0;
  endtask

  task automatic do_set();
    as = 1'b1; cycles(1); as = 1'b0;
  endtask

  task automatic do_start();
    st = 1'b1; cycles(1); st = 1'b0;
  endtask

  initial begin
    ar = 1'b1; cycles(2); ar = 1'b0;
    chk_en = 1'b1;
    check("rst_dcount", int'(dcount), 0);
    check("rst_running", int'(running), 1);
    check("rst_sticky", int'(ovf_sticky), 0);

    // WRAP up through FF
    do_load(8'hFD);
    ci = 1'b1;
    cycles(1); check("wrap_fe", int'(dcount), 8'hFE);
    cycles(1); check("wrap_ff", int'(dcount), 8'hFF);
    check("wrap_carry", int'(carry_out), 1);
    cycles(1); check("wrap_00", int'(dcount), 8'h00);
    check("wrap_ovf", int'(overflow), 1);
    cycles(1); check("wrap_ovf_gone", int'(overflow), 0);
    check("wrap_sticky", int'(ovf_sticky), 1);
    clr = 1'b1; cycles(1); clr = 1'b0;
    check("clr_sticky", int'(ovf_sticky), 0);
    ci = 1'b0;

    // STOP counting down
    md = 2'd1; ud = 1'b0;
    do_load(8'h02);
    ci = 1'b1;
    cycles(2); check("stop_00", int'(dcount), 8'h00);
    cycles(1); check("stop_hold", int'(dcount), 8'h00);
    check("stop_ovf", int'(overflow), 1);
    check("stop_run0", int'(running), 0);
    cycles(2); check("stop_frozen", int'(dcount), 8'h00);
    do_start(); check("stop_restart", int'(running), 1);
    cycles(1); check("stop_ovf2", int'(overflow), 1);
    check("stop_run0b", int'(running), 0);
    check("stop_still00", int'(dcount), 8'h00);
    ci = 1'b0;
    clr = 1'b1; cycles(1); clr = 1'b0;

    // RELOAD after _aset
    md = 2'd2; ud = 1'b1;
    do_start();
    do_load(8'h05);
    do_set(); check("set_ff", int'(dcount), 8'hFF);
    ci = 1'b1; cycles(1); check("reload_05", int'(dcount), 8'h05);
    ci = 1'b0;

    // ONESHOT
    md = 2'd3;
    do_set();
    ci = 1'b1; cycles(1); check("oneshot_05", int'(dcount), 8'h05);
    check("oneshot_run0", int'(running), 0);
    cycles(3); check("oneshot_frozen", int'(dcount), 8'h05);
    do_start(); cycles(1); check("oneshot_resume", int'(dcount), 8'h06);
    ci = 1'b0;

    // Prescaler
    md = 2'd0; presc = 4'd3;
    do_load(8'h00);
    ci = 1'b1;
    cycles(3); check("presc_wait", int'(dcount), 8'h00);
    cycles(1); check("presc_step1", int'(dcount), 8'h01);
    cycles(4); check("presc_step2", int'(dcount), 8'h02);
    cycles(2); ci = 1'b0; cycles(2); ci = 1'b1;
    cycles(1); check("presc_stretch", int'(dcount), 8'h02);
    cycles(1); check("presc_step3", int'(dcount), 8'h03);
    cycles(2); presc = 4'd1;
    cycles(1); check("presc_shrink", int'(dcount), 8'h04);
    presc = 4'd0; ci = 1'b0;

    // Compare match
    cmp = 8'h10;
    do_load(8'h0E);
    ci = 1'b1;
    cycles(1); check("match_0f", int'(match), 0);
    cycles(1); check("match_10", int'(match), 1);
    cycles(1); check("match_pulse", int'(match), 0);
    ci = 1'b0;
    do_load(8'h10); check("match_load", int'(match), 0);

    // Reset dominates everything, including a stopped counter
    md = 2'd1; ud = 1'b1;
    do_set();
    ci = 1'b1; cycles(1); check("pre_rst_run", int'(running), 0);
    ar = 1'b1; as = 1'b1; ld = 1'b1; pv = 8'h33;
    cycles(1);
    ar = 1'b0; as = 1'b0; ld = 1'b0;
    check("all_dcount", int'(dcount), 8'h00);
    check("all_ovf", int'(overflow), 0);
    check("all_run", int'(running), 1);
    ci = 1'b0;

    // _aset beats _load and leaves reload_reg alone
    do_load(8'h05);
    as = 1'b1; ld = 1'b1; pv = 8'h44; cycles(1); as = 1'b0; ld = 1'b0;
    check("setload_ff", int'(dcount), 8'hFF);
    md = 2'd2; ci = 1'b1;
    cycles(1); check("setload_reload", int'(dcount), 8'h05);
    ci = 1'b0;
    cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
